// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: fetch and data-load request/response channels.
interface rom_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     if_req_valid;
  logic [ADDRESS_WIDTH-1:0] if_req_addr;
  logic                     if_req_ready;
  logic                     if_flush;
  logic                     if_rsp_valid;
  logic [DATA_WIDTH-1:0]    if_rsp_data;
  logic                     if_rsp_err;

  logic                     ld_req_valid;
  logic [ADDRESS_WIDTH-1:0] ld_req_addr;
  logic                     ld_req_ready;
  logic                     ld_rsp_valid;
  logic [DATA_WIDTH-1:0]    ld_rsp_data;
  logic                     ld_rsp_err;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush, ld_req_valid, ld_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush, ld_req_valid, ld_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between a fetch and a data-load requester.
// Fixed one-cycle response latency, no backpressure, fetch flush support.
module rom_arbiter #(
  parameter  int unsigned ADDRESS_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned ROM_WORDS     = 1024,
  localparam int unsigned IDX_W         = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_arbiter_if.slave          bus,
  output logic                  rom_en,
  output logic [IDX_W-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [15:0]           grant_cnt_if,
  output logic [15:0]           grant_cnt_ld
);

  localparam logic [ADDRESS_WIDTH:0] ROM_LIMIT = (ADDRESS_WIDTH+1)'(ROM_WORDS);

  logic                     if_can;
  logic                     grant_if;
  logic                     grant_ld;
  logic                     accept;
  logic                     sel_err;
  logic [ADDRESS_WIDTH-1:0] sel_addr;

  logic             last_ld_q, last_ld_d;
  logic             pend_if_q, pend_if_d;
  logic             pend_ld_q, pend_ld_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]      cnt_if_q, cnt_if_d;
  logic [15:0]      cnt_ld_q, cnt_ld_d;

  function automatic logic addr_err(input logic [ADDRESS_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[ADDRESS_WIDTH-1:2]} >= ROM_LIMIT);
  endfunction

  // Arbitration, ROM request and next-state; rst_n gates the combinational handshake.
  always_comb begin
    if_can     = bus.if_req_valid && !bus.if_flush;
    grant_if   = rst_n && if_can && (!bus.ld_req_valid || last_ld_q);
    grant_ld   = rst_n && bus.ld_req_valid && !grant_if;
    accept     = grant_if || grant_ld;
    sel_addr   = grant_if ? bus.if_req_addr : bus.ld_req_addr;
    sel_err    = addr_err(sel_addr);

    rom_en     = accept && !sel_err;
    rom_addr   = rom_en ? sel_addr[IDX_W+1:2] : rom_addr_q;

    bus.if_req_ready = grant_if;
    bus.ld_req_ready = grant_ld;

    last_ld_d  = accept ? grant_ld : last_ld_q;
    pend_if_d  = grant_if;
    pend_ld_d  = grant_ld;
    err_d      = accept && sel_err;
    rom_addr_d = rom_addr;
    cnt_if_d   = cnt_if_q + 16'(grant_if && (cnt_if_q != 16'hFFFF));
    cnt_ld_d   = cnt_ld_q + 16'(grant_ld && (cnt_ld_q != 16'hFFFF));
  end

  // Responses follow the ROM read by one cycle; a flush in the response cycle also kills it.
  always_comb begin
    bus.if_rsp_valid = pend_if_q && !bus.if_flush;
    bus.if_rsp_err   = bus.if_rsp_valid && err_q;
    bus.if_rsp_data  = (bus.if_rsp_valid && !err_q) ? rom_dout : '0;
    bus.ld_rsp_valid = pend_ld_q;
    bus.ld_rsp_err   = bus.ld_rsp_valid && err_q;
    bus.ld_rsp_data  = (bus.ld_rsp_valid && !err_q) ? rom_dout : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ld_q  <= 1'b1;
      pend_if_q  <= 1'b0;
      pend_ld_q  <= 1'b0;
      err_q      <= 1'b0;
      rom_addr_q <= '0;
      cnt_if_q   <= '0;
      cnt_ld_q   <= '0;
    end else begin
      last_ld_q  <= last_ld_d;
      pend_if_q  <= pend_if_d;
      pend_ld_q  <= pend_ld_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
      cnt_if_q   <= cnt_if_d;
      cnt_ld_q   <= cnt_ld_d;
    end
  end

  assign grant_cnt_if = cnt_if_q;
  assign grant_cnt_ld = cnt_ld_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rom_arbiter;
  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned ROM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic [15:0] grant_cnt_if, grant_cnt_ld;
  logic [31:0] mem [ROM_WORDS];

  int checks = 0;
  int failures = 0;

  rom_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WORDS(ROM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .grant_cnt_if(grant_cnt_if), .grant_cnt_ld(grant_cnt_ld)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the enable.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rom_dout <= '0;
    else if (rom_en) rom_dout <= mem[rom_addr];

  // Transaction-level model state
  bit          m_last_ld;
  bit          m_pend, m_pend_ld, m_pend_err;
  int unsigned m_pend_idx, m_last_idx, m_n_if, m_n_ld;

  // Expected outputs for the current cycle
  logic        e_if_ready, e_ld_ready, e_rom_en;
  logic [9:0]  e_rom_addr;
  logic        e_if_rv, e_if_re, e_ld_rv, e_ld_re;
  logic [31:0] e_if_rd, e_ld_rd;
  logic [15:0] e_cnt_if, e_cnt_ld;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= ROM_WORDS);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, ROM_WORDS - 1)) * 4;
    else if (r == 7) return 32'($urandom_range(0, ROM_WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'(ROM_WORDS * 4) + 32'($urandom_range(0, 1000000));
    else             return 32'(ROM_WORDS * 4);
  endfunction

  task automatic reset_model();
    m_last_ld = 1'b1; m_pend = 1'b0; m_pend_ld = 1'b0; m_pend_err = 1'b0;
    m_pend_idx = 0; m_last_idx = 0; m_n_if = 0; m_n_ld = 0;
  endtask

  // Apply one cycle of inputs at the falling edge, then derive expectations and advance the model.
  task automatic drive(input bit ifv, input logic [31:0] ifa, input bit fl,
                       input bit ldv, input logic [31:0] lda);
    int          g;
    logic [31:0] a;
    bit          if_ok;
    @(negedge clk);
    bus.if_req_valid = ifv; bus.if_req_addr = ifa; bus.if_flush = fl;
    bus.ld_req_valid = ldv; bus.ld_req_addr = lda;
    #1;
    if_ok = ifv && !fl;
    if (if_ok && ldv) g = m_last_ld ? 1 : 2;
    else if (if_ok)   g = 1;
    else if (ldv)     g = 2;
    else              g = 0;
    a = (g == 1) ? ifa : lda;
    e_if_ready = (g == 1);
    e_ld_ready = (g == 2);
    e_rom_en   = (g != 0) && !is_bad(a);
    if (e_rom_en) m_last_idx = a / 4;
    e_rom_addr = 10'(m_last_idx);
    e_if_rv = m_pend && !m_pend_ld && !fl;
    e_if_re = e_if_rv && m_pend_err;
    e_if_rd = (e_if_rv && !m_pend_err) ? mem[m_pend_idx] : 32'h0;
    e_ld_rv = m_pend && m_pend_ld;
    e_ld_re = e_ld_rv && m_pend_err;
    e_ld_rd = (e_ld_rv && !m_pend_err) ? mem[m_pend_idx] : 32'h0;
    e_cnt_if = (m_n_if > 65535) ? 16'hFFFF : 16'(m_n_if);
    e_cnt_ld = (m_n_ld > 65535) ? 16'hFFFF : 16'(m_n_ld);
    m_pend     = (g != 0);
    m_pend_ld  = (g == 2);
    m_pend_err = is_bad(a);
    m_pend_idx = is_bad(a) ? 0 : a / 4;
    if (g == 1) m_n_if++;
    if (g == 2) m_n_ld++;
    if (g != 0) m_last_ld = (g == 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_req_valid = 0; bus.if_flush = 0; bus.ld_req_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    bus.if_req_valid = 1; bus.if_req_addr = 32'h10; bus.if_flush = 0;
    bus.ld_req_valid = 1; bus.ld_req_addr = 32'h20;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.if_req_ready !== 1'b0 || bus.ld_req_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready got if=%b ld=%b exp 0", bus.if_req_ready, bus.ld_req_ready); end
    checks++; if (rom_en !== 1'b0 || rom_addr !== 10'd0) begin failures++;
      $display("FAIL reset_rom got en=%b addr=%0d exp 0", rom_en, rom_addr); end
    checks++; if (bus.if_rsp_valid !== 1'b0 || bus.ld_rsp_valid !== 1'b0 || bus.if_rsp_data !== 32'h0
                  || bus.ld_rsp_data !== 32'h0 || bus.if_rsp_err !== 1'b0 || bus.ld_rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset_rsp got ifv=%b ldv=%b exp 0", bus.if_rsp_valid, bus.ld_rsp_valid); end
    checks++; if (grant_cnt_if !== 16'h0 || grant_cnt_ld !== 16'h0) begin failures++;
      $display("FAIL reset_cnt got %h/%h exp 0", grant_cnt_if, grant_cnt_ld); end
    bus.if_req_valid = 0; bus.ld_req_valid = 0;
    rst_n = 1'b1;
    reset_model();
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.if_rsp_valid !== 1'b0 || bus.ld_rsp_valid !== 1'b0) begin failures++;
      $display("FAIL reset_release_rsp got %b/%b exp 0", bus.if_rsp_valid, bus.ld_rsp_valid); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    drive(1, 32'h10, 0, 0, 0);
    checks++; if (bus.if_req_ready !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 10'd4) begin failures++;
      $display("FAIL basic_req got rdy=%b en=%b addr=%0d exp 1/1/4", bus.if_req_ready, rom_en, rom_addr); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== 32'hDEADBEEF) begin failures++;
      $display("FAIL basic_rsp got v=%b d=%h exp 1/deadbeef", bus.if_rsp_valid, bus.if_rsp_data); end
    checks++; if (grant_cnt_if !== 16'd1) begin failures++;
      $display("FAIL basic_cnt got %0d exp 1", grant_cnt_if); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1, 32'($urandom_range(0, ROM_WORDS - 1)) * 4, 0, 1, 32'($urandom_range(0, ROM_WORDS - 1)) * 4);
      else       drive(0, 0, 0, 0, 0);
      if (k < 4) begin
        checks++; if (bus.if_req_ready !== 1'(k % 2 == 0) || bus.ld_req_ready !== 1'(k % 2 == 1)) begin
          failures++; $display("FAIL b2b_grant k=%0d got if=%b ld=%b", k, bus.if_req_ready, bus.ld_req_ready); end
      end
      if (k > 0) begin
        checks++; if (bus.if_rsp_valid !== 1'(k % 2 == 1) || bus.ld_rsp_valid !== 1'(k % 2 == 0)) begin
          failures++; $display("FAIL b2b_rsp k=%0d got if=%b ld=%b", k, bus.if_rsp_valid, bus.ld_rsp_valid); end
        checks++; if (bus.if_rsp_data !== e_if_rd || bus.ld_rsp_data !== e_ld_rd) begin failures++;
          $display("FAIL b2b_data k=%0d got %h/%h exp %h/%h", k, bus.if_rsp_data, bus.ld_rsp_data, e_if_rd, e_ld_rd); end
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(0, 0, 0, 1, 32'h2);
    checks++; if (bus.ld_req_ready !== 1'b1 || rom_en !== 1'b0) begin failures++;
      $display("FAIL err_misalign_req got rdy=%b en=%b exp 1/0", bus.ld_req_ready, rom_en); end
    drive(0, 0, 0, 1, 32'(ROM_WORDS * 4));
    checks++; if (bus.ld_req_ready !== 1'b1 || rom_en !== 1'b0) begin failures++;
      $display("FAIL err_range_req got rdy=%b en=%b exp 1/0", bus.ld_req_ready, rom_en); end
    checks++; if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_err !== 1'b1 || bus.ld_rsp_data !== 32'h0) begin
      failures++; $display("FAIL err_misalign_rsp got v=%b e=%b d=%h exp 1/1/0", bus.ld_rsp_valid, bus.ld_rsp_err, bus.ld_rsp_data); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_err !== 1'b1 || bus.ld_rsp_data !== 32'h0) begin
      failures++; $display("FAIL err_range_rsp got v=%b e=%b d=%h exp 1/1/0", bus.ld_rsp_valid, bus.ld_rsp_err, bus.ld_rsp_data); end
    checks++; if (grant_cnt_ld !== 16'd2) begin failures++;
      $display("FAIL err_cnt got %0d exp 2", grant_cnt_ld); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 32'h40, 0, 0, 0);
    checks++; if (bus.if_req_ready !== 1'b1 || rom_en !== 1'b1) begin failures++;
      $display("FAIL flush_accept got rdy=%b en=%b exp 1/1", bus.if_req_ready, rom_en); end
    drive(1, 32'h44, 1, 1, 32'h80);
    checks++; if (bus.if_rsp_valid !== 1'b0 || bus.if_req_ready !== 1'b0 || bus.ld_req_ready !== 1'b1) begin
      failures++; $display("FAIL flush_cycle got rv=%b ifr=%b ldr=%b exp 0/0/1", bus.if_rsp_valid, bus.if_req_ready, bus.ld_req_ready); end
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.ld_rsp_valid !== 1'b1 || bus.ld_rsp_data !== mem[32] || bus.if_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL flush_ld_rsp got v=%b d=%h ifv=%b exp 1/%h/0", bus.ld_rsp_valid, bus.ld_rsp_data, bus.if_rsp_valid, mem[32]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 32'h100, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++; if (bus.if_rsp_valid !== 1'b1) begin failures++;
      $display("FAIL areset_pending got %b exp 1", bus.if_rsp_valid); end
    bus.ld_req_valid = 1; bus.ld_req_addr = 32'h8;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.if_rsp_valid !== 1'b0 || bus.if_rsp_data !== 32'h0 || bus.ld_req_ready !== 1'b0
                  || bus.if_req_ready !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 10'd0 || grant_cnt_if !== 16'h0) begin
      failures++; $display("FAIL areset_outputs got rv=%b d=%h ldr=%b en=%b addr=%0d cnt=%0d exp 0",
                           bus.if_rsp_valid, bus.if_rsp_data, bus.ld_req_ready, rom_en, rom_addr, grant_cnt_if); end
    @(negedge clk);
    bus.if_req_valid = 0; bus.ld_req_valid = 0;
    rst_n = 1'b1;
    reset_model();
    drive(0, 0, 0, 0, 0);
    checks++; if (bus.if_rsp_valid !== 1'b0 || bus.ld_rsp_valid !== 1'b0) begin failures++;
      $display("FAIL areset_stale got %b/%b exp 0", bus.if_rsp_valid, bus.ld_rsp_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), rand_addr());
      checks++; if ({bus.if_req_ready, bus.ld_req_ready, rom_en} !== {e_if_ready, e_ld_ready, e_rom_en}) begin
        failures++; $display("FAIL rand_req i=%0d got %b%b%b exp %b%b%b", i, bus.if_req_ready, bus.ld_req_ready,
                             rom_en, e_if_ready, e_ld_ready, e_rom_en); end
      checks++; if (rom_addr !== e_rom_addr) begin failures++;
        $display("FAIL rand_rom_addr i=%0d got %0d exp %0d", i, rom_addr, e_rom_addr); end
      checks++; if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {e_if_rv, e_if_re, e_if_rd}) begin
        failures++; $display("FAIL rand_if_rsp i=%0d got %b/%b/%h exp %b/%b/%h", i, bus.if_rsp_valid,
                             bus.if_rsp_err, bus.if_rsp_data, e_if_rv, e_if_re, e_if_rd); end
      checks++; if ({bus.ld_rsp_valid, bus.ld_rsp_err, bus.ld_rsp_data} !== {e_ld_rv, e_ld_re, e_ld_rd}) begin
        failures++; $display("FAIL rand_ld_rsp i=%0d got %b/%b/%h exp %b/%b/%h", i, bus.ld_rsp_valid,
                             bus.ld_rsp_err, bus.ld_rsp_data, e_ld_rv, e_ld_re, e_ld_rd); end
      checks++; if (grant_cnt_if !== e_cnt_if || grant_cnt_ld !== e_cnt_ld) begin failures++;
        $display("FAIL rand_cnt i=%0d got %0d/%0d exp %0d/%0d", i, grant_cnt_if, grant_cnt_ld, e_cnt_if, e_cnt_ld); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      drive(1, 32'h0, 0, 0, 0);
      if (i == 65534) begin
        checks++; if (grant_cnt_if !== 16'hFFFE || grant_cnt_if !== e_cnt_if) begin failures++;
          $display("FAIL sat_edge got %h exp fffe", grant_cnt_if); end
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++; if (grant_cnt_if !== 16'hFFFF || grant_cnt_ld !== 16'h0) begin failures++;
      $display("FAIL sat_final got %h/%h exp ffff/0", grant_cnt_if, grant_cnt_ld); end
  endtask

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    bus.if_req_valid = 0; bus.if_req_addr = 0; bus.if_flush = 0;
    bus.ld_req_valid = 0; bus.ld_req_addr = 0;
    reset_model();
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_errors();
    test_flush();
    test_async_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width on both requester ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 SHALL have parameter ROM_WORDS, default 1024, number of valid ROM words; word index width IDX_W = clog2(ROM_WORDS).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port if_req_valid, input, 1, fetch requester has a request.
REQ-007 SHALL have port if_req_addr, input, ADDRESS_WIDTH, fetch byte address.
REQ-008 SHALL have port if_req_ready, output, 1, fetch request accepted this cycle.
REQ-009 SHALL have port if_flush, input, 1, cancels any in-flight fetch response.
REQ-010 SHALL have port if_rsp_valid, output, 1, fetch response valid.
REQ-011 SHALL have port if_rsp_data, output, DATA_WIDTH, fetch response word.
REQ-012 SHALL have port if_rsp_err, output, 1, fetch response error (misaligned or out of range).
REQ-013 SHALL have ports ld_req_valid/ld_req_addr/ld_req_ready/ld_rsp_valid/ld_rsp_data/ld_rsp_err, same widths and meanings as the fetch equivalents, for the data-load requester (no flush).
REQ-014 SHALL have port rom_en, output, 1, ROM read enable.
REQ-015 SHALL have port rom_addr, output, IDX_W, ROM word index.
REQ-016 SHALL have port rom_dout, input, DATA_WIDTH, ROM read data, valid one cycle after rom_en.
REQ-017 SHALL have port grant_cnt_if and grant_cnt_ld, outputs, 16 each, saturating accepted-request counters.

Function
REQ-018 SHALL accept at most one request per cycle; a request is accepted when req_valid and req_ready are both 1.
REQ-019 SHALL arbitrate round-robin: with both valid, grant the port not granted last; with one valid, grant it regardless of pointer.
REQ-020 SHALL update the last-granted pointer only on an accepted request.
REQ-021 SHALL drive req_ready combinationally, and req_ready SHALL never be 1 on both ports in the same cycle.
REQ-022 SHALL, on an accepted error-free request in cycle N, drive rom_en=1 and rom_addr=addr[IDX_W+1:2] in cycle N; otherwise rom_en=0 and rom_addr holds its last value.
REQ-023 SHALL flag an error when addr[1:0]!=0 or addr>>2 >= ROM_WORDS; an errored request SHALL be accepted, SHALL NOT assert rom_en, and SHALL produce rsp_err=1, rsp_data=0.
REQ-024 SHALL assert exactly one rsp_valid pulse for the granted port in cycle N+1 with rsp_data=rom_dout (or 0 on error); fixed latency 1, no backpressure.
REQ-025 SHALL hold rsp_data at 0 whenever rsp_valid=0.
REQ-026 SHALL suppress if_rsp_valid in cycle N+1 if if_flush=1 in cycle N or N+1; the ROM read still occurs.
REQ-027 SHALL block fetch acceptance (if_req_ready=0) in any cycle if_flush=1; load requests are unaffected.
REQ-028 SHALL increment grant_cnt_* on every accepted request (including errored) and saturate at 16'hFFFF.

Reset
REQ-029 SHALL, while rst_n=0, force if_req_ready=ld_req_ready=0, rom_en=0, rom_addr=0, all rsp_valid/rsp_err=0, rsp_data=0, counters=0, pointer = "last granted load" (fetch wins first tie).
REQ-030 SHALL discard any in-flight response on reset assertion; no rsp_valid in the first cycle after deassertion.

Verification
REQ-031 SHALL pass: only if_req_valid, addr 0x10, rom_dout=0xDEADBEEF next cycle -> rom_addr=4 in N, if_rsp_valid=1, data 0xDEADBEEF in N+1, grant_cnt_if=1.
REQ-032 SHALL pass: both valid for 4 cycles after reset -> grants IF, LD, IF, LD; one rsp_valid per cycle alternating ports.
REQ-033 SHALL pass: ld addr 0x2 then addr ROM_WORDS*4 -> no rom_en, ld_rsp_err=1, data 0 each, counter advances by 2.
REQ-034 SHALL pass: fetch accepted in N, if_flush=1 in N+1 -> if_rsp_valid stays 0; a load accepted in N+1 still responds in N+2.
REQ-035 SHALL pass: rst_n low mid-stream with response pending -> outputs zero immediately (asynchronously), no stale rsp after release.
REQ-036 SHALL pass: 65540 fetch grants -> grant_cnt_if=16'hFFFF, no wrap.
